// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 Hz raster timing, derived totals and coordinate type
// shared by the VGA sync generator and its counters.
package vga_timing_pkg;

  localparam int COORD_W = 10;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  typedef logic [COORD_W-1:0] coord_t;

  // Registered decode of the raster position, kept together so all three
  // flags are always updated on the same edge.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic display_on;
  } sync_t;

  function automatic int span_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic logic in_span(input coord_t v, input coord_t lo,
                                   input coord_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

  localparam int DEF_H_TOTAL = span_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int DEF_V_TOTAL = span_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/vga_wrap_counter.sv
// Enable-gated up counter that wraps from MAX to 0; wrap flags the
// advance that takes it back to zero.
module vga_wrap_counter
  import vga_timing_pkg::*;
#(
  parameter int MAX = DEF_H_TOTAL - 1
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  output coord_t count,
  output logic   wrap
);

  assign wrap = en && (count == coord_t'(MAX));

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values, regardless of block ordering in the simulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + coord_t'(1);
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: coordinates, syncs, active video and strobes,
// all registered together. Define VGA_SYNC_FRAME_CNT_EN to add frame_cnt.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE    = DEF_H_ACTIVE,
  parameter int   H_FP        = DEF_H_FP,
  parameter int   H_SYNC      = DEF_H_SYNC,
  parameter int   H_BP        = DEF_H_BP,
  parameter int   V_ACTIVE    = DEF_V_ACTIVE,
  parameter int   V_FP        = DEF_V_FP,
  parameter int   V_SYNC      = DEF_V_SYNC,
  parameter int   V_BP        = DEF_V_BP,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
  output logic [COORD_W-1:0] hpos,
  output logic [COORD_W-1:0] vpos,
  output logic               hsync,
  output logic               vsync,
  output logic               display_on,
  output logic               line_start,
  output logic               frame_start
`ifdef VGA_SYNC_FRAME_CNT_EN
  ,
  output logic [7:0]         frame_cnt
`endif
);

  localparam int H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam coord_t H_ACT_END = coord_t'(H_ACTIVE);
  localparam coord_t V_ACT_END = coord_t'(V_ACTIVE);
  localparam coord_t H_SYNC_LO = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t H_SYNC_HI = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam coord_t V_SYNC_LO = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t V_SYNC_HI = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic   h_wrap;
  logic   v_wrap;
  coord_t h_next;
  coord_t v_next;
  sync_t  dec_next;
  sync_t  dec_q;

  vga_wrap_counter #(.MAX(H_TOTAL - 1)) u_hcnt (
    .clk   (clk),
    .rst   (rst),
    .en    (ce),
    .count (hpos),
    .wrap  (h_wrap)
  );

  vga_wrap_counter #(.MAX(V_TOTAL - 1)) u_vcnt (
    .clk   (clk),
    .rst   (rst),
    .en    (h_wrap),
    .count (vpos),
    .wrap  (v_wrap)
  );

  // Decode the position the counters are about to take, so the registered
  // flags line up with the registered coordinates.
  always_comb begin
    h_next = hpos;
    v_next = vpos;
    if (ce)     h_next = h_wrap ? '0 : hpos + coord_t'(1);
    if (h_wrap) v_next = v_wrap ? '0 : vpos + coord_t'(1);

    dec_next.hsync      = in_span(h_next, H_SYNC_LO, H_SYNC_HI) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    dec_next.vsync      = in_span(v_next, V_SYNC_LO, V_SYNC_HI) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    dec_next.display_on = (h_next < H_ACT_END) && (v_next < V_ACT_END);
  end

  // h_wrap already includes ce, so the strobes fall on any edge that does
  // not itself wrap, including idle (ce=0) edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      dec_q.hsync      <= ~SYNC_ACTIVE;
      dec_q.vsync      <= ~SYNC_ACTIVE;
      dec_q.display_on <= 1'b1;
      line_start       <= 1'b0;
      frame_start      <= 1'b0;
    end else begin
      dec_q       <= dec_next;
      line_start  <= h_wrap;
      frame_start <= v_wrap;
    end
  end

  assign hsync      = dec_q.hsync;
  assign vsync      = dec_q.vsync;
  assign display_on = dec_q.display_on;

`ifdef VGA_SYNC_FRAME_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if (v_wrap) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: full-size 640x480 instance for line-level timing and a
// shrunken instance (20x12, active-high syncs) for frame-level behaviour.
module tb_vga_sync_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       ce;

  logic [9:0] hpos, vpos;
  logic       hsync, vsync, display_on, line_start, frame_start;
  logic [9:0] s_hpos, s_vpos;
  logic       s_hsync, s_vsync, s_display_on, s_line_start, s_frame_start;
`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [7:0] frame_cnt, s_frame_cnt;
  int         m_fc, sm_fc;
`endif

  int checks = 0;
  int errors = 0;

  // Reference positions and strobes, advanced once per clock edge.
  int m_h, m_v, sm_h, sm_v;
  bit m_ls, m_fs, sm_ls, sm_fs;

  always #5 clk = ~clk;

  vga_sync_gen u_dut (
    .clk         (clk),
    .rst         (rst),
    .ce          (ce),
    .hpos        (hpos),
    .vpos        (vpos),
    .hsync       (hsync),
    .vsync       (vsync),
    .display_on  (display_on),
    .line_start  (line_start),
    .frame_start (frame_start)
`ifdef VGA_SYNC_FRAME_CNT_EN
    ,
    .frame_cnt   (frame_cnt)
`endif
  );

  // Small raster: H 10/2/3/5 (total 20, sync 12..14), V 6/2/2/2 (total 12,
  // sync 8..9), frame = 240 clk.
  vga_sync_gen #(
    .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(5),
    .V_ACTIVE(6),  .V_FP(2), .V_SYNC(2), .V_BP(2),
    .SYNC_ACTIVE(1'b1)
  ) u_small (
    .clk         (clk),
    .rst         (rst),
    .ce          (ce),
    .hpos        (s_hpos),
    .vpos        (s_vpos),
    .hsync       (s_hsync),
    .vsync       (s_vsync),
    .display_on  (s_display_on),
    .line_start  (s_line_start),
    .frame_start (s_frame_start)
`ifdef VGA_SYNC_FRAME_CNT_EN
    ,
    .frame_cnt   (s_frame_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_h = 0; m_v = 0; m_ls = 0; m_fs = 0;
      sm_h = 0; sm_v = 0; sm_ls = 0; sm_fs = 0;
`ifdef VGA_SYNC_FRAME_CNT_EN
      m_fc = 0; sm_fc = 0;
`endif
    end else if (ce) begin
      m_ls = (m_h == 799);
      m_fs = m_ls && (m_v == 524);
      if (m_ls) begin m_h = 0; m_v = (m_v == 524) ? 0 : m_v + 1; end
      else m_h = m_h + 1;
      sm_ls = (sm_h == 19);
      sm_fs = sm_ls && (sm_v == 11);
      if (sm_ls) begin sm_h = 0; sm_v = (sm_v == 11) ? 0 : sm_v + 1; end
      else sm_h = sm_h + 1;
`ifdef VGA_SYNC_FRAME_CNT_EN
      if (m_fs)  m_fc  = (m_fc + 1) % 256;
      if (sm_fs) sm_fc = (sm_fc + 1) % 256;
`endif
    end else begin
      m_ls = 0; m_fs = 0; sm_ls = 0; sm_fs = 0;
    end
    #1;
  endtask

  function automatic logic [24:0] exp_def();
    logic [9:0] h = 10'(m_h);
    logic [9:0] v = 10'(m_v);
    return {h, v, !(m_h >= 656 && m_h <= 751), !(m_v >= 490 && m_v <= 491),
            (m_h < 640 && m_v < 480), m_ls, m_fs};
  endfunction

  function automatic logic [24:0] exp_small();
    logic [9:0] h = 10'(sm_h);
    logic [9:0] v = 10'(sm_v);
    return {h, v, (sm_h >= 12 && sm_h <= 14), (sm_v >= 8 && sm_v <= 9),
            (sm_h < 10 && sm_v < 6), sm_ls, sm_fs};
  endfunction

  function automatic logic [24:0] got_def();
    return {hpos, vpos, hsync, vsync, display_on, line_start, frame_start};
  endfunction

  function automatic logic [24:0] got_small();
    return {s_hpos, s_vpos, s_hsync, s_vsync, s_display_on, s_line_start, s_frame_start};
  endfunction

  task automatic test_reset();
    rst = 1'b1; ce = 1'b1;
    tick();
    checks++; if (hpos !== 10'd0) begin errors++; $display("FAIL reset_hpos: got %0d want 0", hpos); end
    checks++; if (vpos !== 10'd0) begin errors++; $display("FAIL reset_vpos: got %0d want 0", vpos); end
    checks++; if (display_on !== 1'b1) begin errors++; $display("FAIL reset_display_on: got %b want 1", display_on); end
    checks++; if (hsync !== 1'b1) begin errors++; $display("FAIL reset_hsync: got %b want 1", hsync); end
    checks++; if (vsync !== 1'b1) begin errors++; $display("FAIL reset_vsync: got %b want 1", vsync); end
    checks++; if (line_start !== 1'b0) begin errors++; $display("FAIL reset_line_start: got %b want 0", line_start); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame_start: got %b want 0", frame_start); end
    checks++; if (s_hsync !== 1'b0) begin errors++; $display("FAIL reset_small_hsync: got %b want 0", s_hsync); end
    checks++; if (s_vsync !== 1'b0) begin errors++; $display("FAIL reset_small_vsync: got %b want 0", s_vsync); end
`ifdef VGA_SYNC_FRAME_CNT_EN
    checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); end
`endif
  endtask

  task automatic test_first_line();
    int ls_cnt = 0, ls_at = -1, hs_low = 0, hs_first = -1, hs_last = -1, disp_off = 0;
    rst = 1'b0; ce = 1'b1;
    for (int i = 1; i <= 800; i++) begin
      tick();
      checks++;
      if (got_def() !== exp_def()) begin
        errors++; $display("FAIL line_vec cycle %0d: got %h want %h", i, got_def(), exp_def());
      end
      if (line_start) begin ls_cnt++; ls_at = i; end
      if (!hsync) begin hs_low++; if (hs_first < 0) hs_first = int'(hpos); hs_last = int'(hpos); end
      if (!display_on) disp_off++;
    end
    checks++; if (ls_cnt != 1) begin errors++; $display("FAIL line_start_count: got %0d want 1", ls_cnt); end
    checks++; if (ls_at != 800) begin errors++; $display("FAIL line_start_cycle: got %0d want 800", ls_at); end
    checks++; if (hs_low != 96) begin errors++; $display("FAIL hsync_width: got %0d want 96", hs_low); end
    checks++; if (hs_first != 656) begin errors++; $display("FAIL hsync_first: got %0d want 656", hs_first); end
    checks++; if (hs_last != 751) begin errors++; $display("FAIL hsync_last: got %0d want 751", hs_last); end
    checks++; if (disp_off != 160) begin errors++; $display("FAIL blank_width: got %0d want 160", disp_off); end
    checks++; if (hpos !== 10'd0 || vpos !== 10'd1) begin
      errors++; $display("FAIL line_wrap_pos: got (%0d,%0d) want (0,1)", hpos, vpos);
    end
  endtask

  task automatic test_frame();
    int fs_cnt = 0, fs_at = -1, vs_cnt = 0, disp_cnt = 0, ls_cnt = 0;
    rst = 1'b1; ce = 1'b1; tick();
    rst = 1'b0;
    for (int i = 1; i <= 240; i++) begin
      tick();
      checks++;
      if (got_small() !== exp_small()) begin
        errors++; $display("FAIL frame_vec cycle %0d: got %h want %h", i, got_small(), exp_small());
      end
      if (s_frame_start) begin fs_cnt++; fs_at = i; end
      if (s_frame_start && !s_line_start) begin
        errors++; $display("FAIL frame_without_line cycle %0d: line_start %b want 1", i, s_line_start);
      end
      if (s_vsync) vs_cnt++;
      if (s_display_on) disp_cnt++;
      if (s_line_start) ls_cnt++;
    end
    checks++; if (fs_cnt != 1) begin errors++; $display("FAIL frame_start_count: got %0d want 1", fs_cnt); end
    checks++; if (fs_at != 240) begin errors++; $display("FAIL frame_start_cycle: got %0d want 240", fs_at); end
    checks++; if (vs_cnt != 40) begin errors++; $display("FAIL vsync_width: got %0d want 40", vs_cnt); end
    checks++; if (disp_cnt != 60) begin errors++; $display("FAIL display_count: got %0d want 60", disp_cnt); end
    checks++; if (ls_cnt != 12) begin errors++; $display("FAIL frame_line_count: got %0d want 12", ls_cnt); end
    checks++; if (frame_start !== 1'b0 || vpos !== 10'd0) begin
      errors++; $display("FAIL big_no_frame: got fs=%b vpos=%0d want fs=0 vpos=0", frame_start, vpos);
    end
  endtask

  task automatic test_ce_toggle();
    int ls_cnt = 0, ls_at = -1, s_cnt = 0, s_last = -1, bad_gap = 0;
    rst = 1'b1; ce = 1'b1; tick();
    rst = 1'b0;
    for (int i = 1; i <= 1600; i++) begin
      ce = (i % 2 == 1);
      tick();
      checks++;
      if (got_def() !== exp_def() || got_small() !== exp_small()) begin
        errors++;
        $display("FAIL ce_vec cycle %0d: got %h/%h want %h/%h", i, got_def(), got_small(), exp_def(), exp_small());
      end
      if (line_start) begin ls_cnt++; ls_at = i; end
      if (s_line_start) begin
        if (s_last >= 0 && i - s_last != 40) bad_gap++;
        s_last = i; s_cnt++;
      end
    end
    ce = 1'b1;
    checks++; if (ls_cnt != 1 || ls_at != 1599) begin
      errors++; $display("FAIL ce_line_period: got %0d strobes at %0d want 1 at 1599", ls_cnt, ls_at);
    end
    checks++; if (s_cnt != 40 || bad_gap != 0) begin
      errors++; $display("FAIL ce_small_period: got %0d strobes %0d bad gaps want 40 and 0", s_cnt, bad_gap);
    end
  endtask

  task automatic test_mid_reset();
    rst = 1'b1; ce = 1'b1; tick();
    rst = 1'b0;
    repeat (173) tick();
    checks++; if (s_hpos !== 10'd13 || s_vpos !== 10'd8 || s_hsync !== 1'b1 || s_vsync !== 1'b1) begin
      errors++; $display("FAIL pre_reset_pos: got (%0d,%0d) hs=%b vs=%b want (13,8) 1 1", s_hpos, s_vpos, s_hsync, s_vsync);
    end
    rst = 1'b1; tick();
    rst = 1'b0;
    checks++; if (got_small() !== {10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL mid_reset_small: got %h want %h", got_small(), {10'd0, 10'd0, 5'b00100});
    end
    checks++; if (got_def() !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL mid_reset_big: got %h want %h", got_def(), {10'd0, 10'd0, 5'b11100});
    end
    repeat (239) tick();
    checks++; if (s_hpos !== 10'd19 || s_vpos !== 10'd11) begin
      errors++; $display("FAIL frame_end_pos: got (%0d,%0d) want (19,11)", s_hpos, s_vpos);
    end
    rst = 1'b1; tick();
    rst = 1'b0;
    checks++; if (s_frame_start !== 1'b0 || s_line_start !== 1'b0 || s_hpos !== 10'd0 || s_vpos !== 10'd0) begin
      errors++; $display("FAIL reset_at_wrap: got fs=%b ls=%b (%0d,%0d) want 0 0 (0,0)", s_frame_start, s_line_start, s_hpos, s_vpos);
    end
    tick();
    checks++; if (s_hpos !== 10'd1 || s_frame_start !== 1'b0) begin
      errors++; $display("FAIL after_reset_step: got hpos=%0d fs=%b want 1 0", s_hpos, s_frame_start);
    end
  endtask

`ifdef VGA_SYNC_FRAME_CNT_EN
  task automatic test_frame_cnt();
    rst = 1'b1; ce = 1'b1; tick();
    rst = 1'b0;
    for (int i = 1; i <= 257 * 240; i++) begin
      tick();
      checks++;
      if (s_frame_cnt !== 8'(sm_fc)) begin
        errors++; $display("FAIL frame_cnt cycle %0d: got %0d want %0d", i, s_frame_cnt, sm_fc);
      end
    end
    checks++; if (s_frame_cnt !== 8'd1) begin errors++; $display("FAIL frame_cnt_wrap: got %0d want 1", s_frame_cnt); end
    checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL big_frame_cnt: got %0d want 0", frame_cnt); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    ce  = 1'b0;
    test_reset();
    test_first_line();
    test_frame();
    test_ce_toggle();
    test_mid_reset();
`ifdef VGA_SYNC_FRAME_CNT_EN
    test_frame_cnt();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
